// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin arbiter sharing one data-memory port between the
//            instruction refill path (I) and the data cache (D).
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int MEM_RD_LAT = 1,
    parameter int AW         = 16
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          i_req,
    input  logic [7:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [63:0]   i_wdata,
    output logic          i_ack,
    output logic [63:0]   i_rdata,

    input  logic          d_req,
    input  logic [7:0]    d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [63:0]   d_wdata,
    output logic          d_ack,
    output logic [63:0]   d_rdata,

    output logic [AW-1:0] rdaddress,
    output logic          rden,
    input  logic [63:0]   read_data,

    output logic [AW-1:0] wraddress,
    output logic [7:0]    wren,
    output logic [63:0]   write_data,

    output logic          busy,
    output logic          owner
);

    localparam int CW = $clog2(MEM_RD_LAT) + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic            r_owner;
    logic            r_last_grant;
    logic [AW-1:0]   r_addr;
    logic [7:0]      r_we;
    logic [63:0]     r_wdata;
    logic [63:0]     r_i_rdata;
    logic [63:0]     r_d_rdata;
    logic [CW-1:0]   r_cnt;

    logic            w_any_req;
    logic            w_grant_d;
    logic            w_cnt_done;
    logic [7:0]      w_sel_we;
    logic [AW-1:0]   w_sel_addr;
    logic [63:0]     w_sel_wdata;

    // On a tie D wins unless it was the last one granted.
    always_comb begin
        w_any_req   = i_req | d_req;
        w_grant_d   = d_req & (~i_req | ~r_last_grant);
        w_cnt_done  = (r_cnt == CW'(MEM_RD_LAT - 1));
        w_sel_we    = w_grant_d ? d_we    : i_we;
        w_sel_addr  = w_grant_d ? d_addr  : i_addr;
        w_sel_wdata = w_grant_d ? d_wdata : i_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next = (w_sel_we != 8'h00) ? S_WR : S_RD;
                end
            end
            S_RD:   w_next = S_WAIT;
            S_WAIT: begin
                if (w_cnt_done) begin
                    w_next = S_RESP;
                end
            end
            S_WR:   w_next = S_RESP;
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner      <= 1'b0;
            r_last_grant <= 1'b0;
            r_addr       <= '0;
            r_we         <= '0;
            r_wdata      <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_cnt        <= '0;
        end else begin
            if (r_state == S_IDLE && w_any_req) begin
                r_owner      <= w_grant_d;
                r_last_grant <= w_grant_d;
                r_addr       <= w_sel_addr;
                r_we         <= w_sel_we;
                r_wdata      <= w_sel_wdata;
            end

            if (r_state == S_RD) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT && !w_cnt_done) begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Only the owner's read register is updated; the other holds.
            if (r_state == S_WAIT && w_cnt_done) begin
                if (r_owner) begin
                    r_d_rdata <= read_data;
                end else begin
                    r_i_rdata <= read_data;
                end
            end
        end
    end

    assign rden       = (r_state == S_RD);
    assign wren       = (r_state == S_WR) ? r_we : 8'h00;
    assign rdaddress  = r_addr;
    assign wraddress  = r_addr;
    assign write_data = r_wdata;
    assign i_ack      = (r_state == S_RESP) & ~r_owner;
    assign d_ack      = (r_state == S_RESP) &  r_owner;
    assign i_rdata    = r_i_rdata;
    assign d_rdata    = r_d_rdata;
    assign busy       = (r_state != S_IDLE);
    assign owner      = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter with latencies 1 and 3.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Index [g][r]: g = DUT instance (0: latency 1, 1: latency 3), r = 0:I, 1:D
    logic        req   [2][2];
    logic [7:0]  we    [2][2];
    logic [15:0] addr  [2][2];
    logic [63:0] wdata [2][2];
    logic        ack   [2][2];
    logic [63:0] rdata [2][2];

    logic [15:0] rdaddress  [2];
    logic [15:0] wraddress  [2];
    logic        rden       [2];
    logic [7:0]  wren       [2];
    logic [63:0] write_data [2];
    logic [63:0] read_data  [2];
    logic        busy       [2];
    logic        owner      [2];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int viol     = 0;

    logic [63:0] ref_mem [2][256];
    logic [63:0] last_rd [2][2];

    function automatic logic [63:0] pat(input logic [7:0] a);
        if (a == 8'h40) return 64'h1122334455667788;
        return {8{a ^ 8'h5A}} ^ {a, 56'h0123456789ABCD};
    endfunction

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            localparam int LAT = (g == 0) ? 1 : 3;
            logic [63:0] mem [256];
            logic [63:0] pd  [LAT];
            logic        pv  [LAT];
            logic [63:0] junk;
            bit          init_done = 1'b0;

            mem_arbiter #(.MEM_RD_LAT(LAT), .AW(16)) u_dut (
                .clk        (clk),
                .rst        (rst),
                .i_req      (req[g][0]),
                .i_we       (we[g][0]),
                .i_addr     (addr[g][0]),
                .i_wdata    (wdata[g][0]),
                .i_ack      (ack[g][0]),
                .i_rdata    (rdata[g][0]),
                .d_req      (req[g][1]),
                .d_we       (we[g][1]),
                .d_addr     (addr[g][1]),
                .d_wdata    (wdata[g][1]),
                .d_ack      (ack[g][1]),
                .d_rdata    (rdata[g][1]),
                .rdaddress  (rdaddress[g]),
                .rden       (rden[g]),
                .read_data  (read_data[g]),
                .wraddress  (wraddress[g]),
                .wren       (wren[g]),
                .write_data (write_data[g]),
                .busy       (busy[g]),
                .owner      (owner[g])
            );

            // Memory with LAT-cycle read pipeline; random junk outside the valid cycle.
            always @(posedge clk) begin
                junk <= {$urandom, $urandom};
                if (!init_done) begin
                    for (int a = 0; a < 256; a++) mem[a] <= pat(8'(a));
                    init_done <= 1'b1;
                end else if (wren[g] != 8'h00) begin
                    for (int b = 0; b < 8; b++)
                        if (wren[g][b]) mem[wraddress[g][7:0]][8*b +: 8] <= write_data[g][8*b +: 8];
                end
                pv[0] <= rden[g];
                pd[0] <= mem[rdaddress[g][7:0]];
                for (int k = 1; k < LAT; k++) begin
                    pv[k] <= pv[k-1];
                    pd[k] <= pd[k-1];
                end
            end
            assign read_data[g] = pv[LAT-1] ? pd[LAT-1] : junk;
        end
    endgenerate

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++)
            if (rden[g] && wren[g] != 8'h00) viol <= viol + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic drive(input int g, input int r, input logic v, input logic [7:0] w,
                         input logic [15:0] a, input logic [63:0] d);
        req[g][r]   = v;
        we[g][r]    = w;
        addr[g][r]  = a;
        wdata[g][r] = d;
    endtask

    task automatic ref_write(input int g, input logic [7:0] w, input logic [15:0] a,
                             input logic [63:0] d);
        for (int b = 0; b < 8; b++)
            if (w[b]) ref_mem[g][a[7:0]][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int g = 0; g < 2; g++)
            for (int r = 0; r < 2; r++) last_rd[g][r] = '0;
    endtask

    // Single transaction; checks ack latency and data against the reference memory.
    task automatic txn(input int g, input int r, input logic [7:0] w, input logic [15:0] a,
                       input logic [63:0] d, input string tag);
        int c0;
        int got;
        int exp_lat;
        c0 = cyc;
        got = 0;
        exp_lat = (w != 8'h00) ? 2 : lat_of(g) + 2;
        drive(g, r, 1'b1, w, a, d);
        for (int t = 0; t < 20 && got == 0; t++) begin
            @(negedge clk);
            if (ack[g][r]) got = 1;
        end
        req[g][r] = 1'b0;
        chk({tag, "_lat"}, 64'(cyc - c0), 64'(exp_lat));
        if (w == 8'h00) chk({tag, "_rdata"}, rdata[g][r], ref_mem[g][a[7:0]]);
        else ref_write(g, w, a, d);
        @(negedge clk);
        chk({tag, "_idle"}, busy[g], 1'b0);
    endtask

    // Both requesters saturate; grants must alternate D, I, D ... after reset.
    task automatic saturate(input int g, input int n, input bit only_wr);
        logic [7:0]  cw [2];
        logic [15:0] ca [2];
        logic [63:0] cd [2];
        int exp_r;
        int prev;
        int got;
        int r;
        int dur;
        exp_r = 1;
        prev = cyc - 1;
        for (int q = 0; q < 2; q++) begin
            cw[q] = (only_wr || $urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
            ca[q] = 16'($urandom);
            cd[q] = {$urandom, $urandom};
            drive(g, q, 1'b1, cw[q], ca[q], cd[q]);
        end
        for (int k = 0; k < n; k++) begin
            got = 0;
            for (int t = 0; t < 20 && got == 0; t++) begin
                @(negedge clk);
                if (ack[g][0] || ack[g][1]) got = 1;
            end
            if (got == 0) begin
                chk("sat_timeout", 1'b1, 1'b0);
                break;
            end
            r = ack[g][1] ? 1 : 0;
            dur = (cw[r] != 8'h00) ? 3 : lat_of(g) + 3;
            chk("sat_grant", 64'(r), 64'(exp_r));
            chk("sat_one_ack", ack[g][0] & ack[g][1], 1'b0);
            chk("sat_owner", owner[g], exp_r[0]);
            chk("sat_gap", 64'(cyc - prev), 64'(dur));
            chk("sat_other_hold", rdata[g][1-r], last_rd[g][1-r]);
            if (cw[r] == 8'h00) begin
                chk("sat_rdata", rdata[g][r], ref_mem[g][ca[r][7:0]]);
                last_rd[g][r] = ref_mem[g][ca[r][7:0]];
            end else begin
                chk("sat_rdata_hold", rdata[g][r], last_rd[g][r]);
                ref_write(g, cw[r], ca[r], cd[r]);
            end
            prev = cyc;
            exp_r = 1 - exp_r;
            cw[r] = (only_wr || $urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
            ca[r] = 16'($urandom);
            cd[r] = {$urandom, $urandom};
            drive(g, r, 1'b1, cw[r], ca[r], cd[r]);
        end
        req[g][0] = 1'b0;
        req[g][1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("sat_idle", busy[g], 1'b0);
    endtask

    initial begin
        int n_ack;
        bit rd_seen;
        for (int g = 0; g < 2; g++) begin
            for (int r = 0; r < 2; r++) begin
                drive(g, r, 1'b0, 8'h00, 16'h0000, 64'h0);
                last_rd[g][r] = '0;
            end
            for (int a = 0; a < 256; a++) ref_mem[g][a] = pat(8'(a));
        end

        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_busy", busy[g], 1'b0);
            chk("rst_rden", rden[g], 1'b0);
            chk("rst_wren", wren[g], 8'h00);
            chk("rst_owner", owner[g], 1'b0);
            chk("rst_iack", ack[g][0], 1'b0);
            chk("rst_dack", ack[g][1], 1'b0);
            chk("rst_rdata", rdata[g][1], 64'h0);
            chk("rst_wdata", write_data[g], 64'h0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Single D read, latency 1
        drive(0, 1, 1'b1, 8'h00, 16'h0040, 64'h0);
        @(negedge clk);
        chk("rd1_rden", rden[0], 1'b1);
        chk("rd1_rdaddr", rdaddress[0], 16'h0040);
        chk("rd1_owner", owner[0], 1'b1);
        @(negedge clk);
        chk("rd1_ack_early", ack[0][1], 1'b0);
        @(negedge clk);
        chk("rd1_dack", ack[0][1], 1'b1);
        chk("rd1_drdata", rdata[0][1], 64'h1122334455667788);
        chk("rd1_iack", ack[0][0], 1'b0);
        req[0][1] = 1'b0;
        @(negedge clk);
        chk("rd1_idle", busy[0], 1'b0);

        // Single I write
        rd_seen = 1'b0;
        drive(0, 0, 1'b1, 8'h0F, 16'h0100, 64'hDEADBEEF);
        @(negedge clk);
        rd_seen |= rden[0];
        chk("wr_wren", wren[0], 8'h0F);
        chk("wr_wraddr", wraddress[0], 16'h0100);
        chk("wr_wdata", write_data[0], 64'hDEADBEEF);
        @(negedge clk);
        rd_seen |= rden[0];
        chk("wr_iack", ack[0][0], 1'b1);
        chk("wr_irdata_hold", rdata[0][0], 64'h0);
        req[0][0] = 1'b0;
        ref_write(0, 8'h0F, 16'h0100, 64'hDEADBEEF);
        @(negedge clk);
        chk("wr_no_rden", rd_seen, 1'b0);
        txn(0, 1, 8'h00, 16'h0100, 64'h0, "wr_readback");

        // Request address changed in RD and req dropped in WAIT
        drive(0, 0, 1'b1, 8'h00, 16'h0020, 64'h0);
        @(negedge clk);
        chk("chg_rdaddr", rdaddress[0], 16'h0020);
        addr[0][0] = 16'h0033;
        @(negedge clk);
        req[0][0] = 1'b0;
        @(negedge clk);
        chk("chg_iack", ack[0][0], 1'b1);
        chk("chg_irdata", rdata[0][0], ref_mem[0][8'h20]);
        @(negedge clk);
        chk("chg_idle1", busy[0], 1'b0);
        @(negedge clk);
        chk("chg_idle2", busy[0], 1'b0);

        // Latency-3 read on instance 1
        drive(1, 1, 1'b1, 8'h00, 16'h0008, 64'h0);
        @(negedge clk);
        chk("l3_rden", rden[1], 1'b1);
        repeat (3) @(negedge clk);
        chk("l3_ack_t4", ack[1][1], 1'b0);
        chk("l3_busy_t4", busy[1], 1'b1);
        @(negedge clk);
        chk("l3_ack_t5", ack[1][1], 1'b1);
        chk("l3_rdata", rdata[1][1], ref_mem[1][8'h08]);
        req[1][1] = 1'b0;
        @(negedge clk);

        // Asynchronous reset while waiting for read data
        drive(1, 1, 1'b1, 8'h00, 16'h0010, 64'h0);
        repeat (2) @(negedge clk);
        chk("ar_busy_pre", busy[1], 1'b1);
        rst = 1'b1;
        #1;
        chk("ar_busy", busy[1], 1'b0);
        chk("ar_rden", rden[1], 1'b0);
        chk("ar_dack", ack[1][1], 1'b0);
        chk("ar_owner", owner[1], 1'b0);
        chk("ar_drdata", rdata[1][1], 64'h0);
        req[1][1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_ack = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack[1][0] || ack[1][1]) n_ack++;
        end
        chk("ar_no_ack", 64'(n_ack), 64'h0);
        txn(1, 1, 8'h00, 16'h0010, 64'h0, "ar_after");
        for (int g = 0; g < 2; g++)
            for (int r = 0; r < 2; r++) last_rd[g][r] = '0;

        // Saturation: directed writes, then random mixed traffic on both latencies
        do_reset();
        saturate(0, 4, 1'b1);
        do_reset();
        saturate(0, 24, 1'b0);
        do_reset();
        saturate(1, 24, 1'b0);

        chk("rd_wr_excl", 64'(viol), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
